// File: rtl/muldiv_ctrl_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: op codes, FSM encoding,
// iteration count and the divide-by-zero quotient.
package muldiv_ctrl_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int          MD_ITER = 32;
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

    // Magnitude of a two's-complement value when the op is signed; raw otherwise.
    function automatic logic [31:0] md_abs(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative shift-add multiply / restoring divide engine with final sign fix.
// MULDIV_FAST_MUL_EN: multiplies load a full combinational product at start.
module muldiv_core
    import muldiv_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            load,
    input  logic            step,
    input  logic            op_div,
    input  logic            op_signed,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            last,
    output logic [XLEN-1:0] hi_res,
    output logic [XLEN-1:0] lo_res
);

    localparam int CW = $clog2(MD_ITER);

    logic [2*XLEN-1:0] acc_reg;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN-1:0]   opb_reg;
    logic [XLEN-1:0]   raw1_reg;
    logic [CW-1:0]     cnt_reg;
    logic              div_reg;
    logic              neg_res_reg;
    logic              neg_rem_reg;
    logic              div0_reg;

    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN+1:0]   div_diff;
    logic [2*XLEN-1:0] prod;

    assign mag1 = md_abs(src1, op_signed);
    assign mag2 = md_abs(src2, op_signed);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a;
    logic [2*XLEN-1:0] fast_b;
    logic [2*XLEN-1:0] fast_prod;

    // Sign-extend to 64 bits; the low 64 bits of the product are exact either way.
    assign fast_a    = {{XLEN{op_signed & src1[XLEN-1]}}, src1};
    assign fast_b    = {{XLEN{op_signed & src2[XLEN-1]}}, src2};
    assign fast_prod = fast_a * fast_b;
`endif

    // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opb_reg} : '0);
        div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb_reg};
        if (div_reg) begin
            if (!div_diff[XLEN+1]) begin
                acc_next = {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum, acc_reg[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc_reg     <= '0;
            opb_reg     <= '0;
            raw1_reg    <= '0;
            cnt_reg     <= '0;
            div_reg     <= 1'b0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            div0_reg    <= 1'b0;
        end else if (load) begin
            cnt_reg     <= '0;
            div_reg     <= op_div;
            raw1_reg    <= src1;
            div0_reg    <= (src2 == '0);
            neg_res_reg <= op_signed && (src1[XLEN-1] ^ src2[XLEN-1]);
            neg_rem_reg <= op_signed && src1[XLEN-1];
            if (op_div) begin
                acc_reg <= {{XLEN{1'b0}}, mag1};
                opb_reg <= mag2;
            end else begin
`ifdef MULDIV_FAST_MUL_EN
                acc_reg     <= fast_prod;
                opb_reg     <= '0;
                neg_res_reg <= 1'b0;
`else
                acc_reg <= {{XLEN{1'b0}}, mag2};
                opb_reg <= mag1;
`endif
            end
        end else if (step) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign last = (cnt_reg == CW'(MD_ITER - 1));
    assign prod = neg_res_reg ? ((2*XLEN)'(0) - acc_reg) : acc_reg;

    always_comb begin
        hi_res = prod[2*XLEN-1:XLEN];
        lo_res = prod[XLEN-1:0];
        if (div_reg) begin
            if (div0_reg) begin
                hi_res = raw1_reg;
                lo_res = DIV0_LO;
            end else begin
                lo_res = neg_res_reg ? (XLEN'(0) - acc_reg[XLEN-1:0]) : acc_reg[XLEN-1:0];
                hi_res = neg_rem_reg ? (XLEN'(0) - acc_reg[2*XLEN-1:XLEN])
                                     : acc_reg[2*XLEN-1:XLEN];
            end
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner and sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO with WB cancel.
// MULDIV_FAST_MUL_EN: multiplies skip the iterative MUL state and commit after one cycle.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] HILO_RESET = 32'h0
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            op_valid,
    input  logic [2:0]      op_code,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            cancel,
    output logic            op_ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    md_state_e       state_reg;
    logic            busy_reg;
    logic            done_reg;
    logic [XLEN-1:0] hi_reg;
    logic [XLEN-1:0] lo_reg;

    logic            accept;
    logic            is_mul;
    logic            is_div;
    logic            op_signed;
    logic            core_load;
    logic            core_step;
    logic            core_last;
    logic [XLEN-1:0] core_hi;
    logic [XLEN-1:0] core_lo;

    assign is_mul    = (op_code == MD_MULT) || (op_code == MD_MULTU);
    assign is_div    = (op_code == MD_DIV)  || (op_code == MD_DIVU);
    assign op_signed = (op_code == MD_MULT) || (op_code == MD_DIV);
    assign accept    = op_valid && !cancel && (state_reg == ST_IDLE);
    assign core_load = accept && (is_mul || is_div);
    assign core_step = !cancel && ((state_reg == ST_MUL) || (state_reg == ST_DIV));

    muldiv_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk       (clk),
        .resetn    (resetn),
        .load      (core_load),
        .step      (core_step),
        .op_div    (is_div),
        .op_signed (op_signed),
        .src1      (src1),
        .src2      (src2),
        .last      (core_last),
        .hi_res    (core_hi),
        .lo_res    (core_lo)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            hi_reg    <= HILO_RESET;
            lo_reg    <= HILO_RESET;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        case (op_code)
                            MD_MTHI: hi_reg <= src1;
                            MD_MTLO: lo_reg <= src1;
                            MD_MULT, MD_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
                                state_reg <= ST_FIX;
`else
                                state_reg <= ST_MUL;
`endif
                                busy_reg  <= 1'b1;
                            end
                            MD_DIV, MD_DIVU: begin
                                state_reg <= ST_DIV;
                                busy_reg  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (cancel) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else if (core_last) begin
                        state_reg <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    // A cancel here still beats the commit: HI/LO must not see a flushed op.
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    if (!cancel) begin
                        hi_reg   <= core_hi;
                        lo_reg   <= core_lo;
                        done_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign op_ready = ~busy_reg;
    assign done     = done_reg;
    assign hi_o     = hi_reg;
    assign lo_o     = lo_reg;

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Owns the architectural HI/LO registers and sequences every MULT/MULTU/DIV/DIVU/MTHI/MTLO through one shared iterative shift-add/restoring datapath.
- Accepts one op at a time from the EXE stage and asserts busy so issue stalls. mfhi/mflo in WB read hi_o/lo_o directly.
- An exception cancel from WB aborts an in-flight op without touching HI/LO.

Parameters:
- XLEN, 32, operand width; only 32 is supported.
- HILO_RESET, 32'h0, value loaded into HI and LO on reset.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset, sampled on rising clk
- op_valid  in  1  op presented this cycle
- op_code  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 ignored
- src1  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data)
- src2  in  32  rt operand (divisor / multiplier)
- cancel  in  1  WB exception flush
- op_ready  out  1  =~busy; op accepted when op_valid & op_ready & ~cancel
- busy  out  1  iterative op in flight; EXE/issue stall
- done  out  1  one-cycle pulse: iterative result committed to HI/LO
- hi_o  out  32  current HI
- lo_o  out  32  current LO

Behaviour:
- Reset (resetn=0 at edge): state=IDLE, busy=0, done=0, hi_o=lo_o=HILO_RESET, cnt=0. Applies mid-operation; the partial result is discarded.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE:
  - MTHI/MTLO accepted at edge E0 → HI (or LO) = src1 after E0. Stays IDLE, no busy, no done.
  - MULT/MULTU/DIV/DIVU accepted at E0 → latch |src1|, |src2| (magnitudes only for signed ops), sign flags, cnt=0. Go to MUL or DIV.
- MUL: one shift-add step per edge, E1..E32, into a 64-bit accumulator. After cnt==31 go to FIX.
- DIV: one restoring step per edge, E1..E32; produces quotient bit 31-cnt. After cnt==31 go to FIX.
- FIX (edge E33), sign correction and commit:
  - Signed mult: negate the 64-bit product if the operand signs differ.
  - Signed div: negate the quotient if signs differ; the remainder takes the dividend's sign.
  - Commit {HI,LO} = product, or HI=remainder, LO=quotient. Go to IDLE.
  - done=1 during the cycle after E33.
- Latency: busy=1 during the cycles following E0..E32 (33 cycles); op_ready=1 again in the cycle after E33.
- Divide by zero (src2==0), any signedness: LO=32'hFFFFFFFF, HI=src1 (raw). Same 33-cycle timing.
- DIV 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0 (wraps, no trap).
- op_valid while busy: ignored, no state change. Upstream holds the op under stall.
- cancel:
  - cancel in MUL/DIV/FIX → IDLE at the next edge, HI/LO unchanged, no done.
  - cancel in the same cycle as op_valid in IDLE → op not accepted, MTHI/MTLO included.
- Invalid op_code (6,7) with op_valid: no effect.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU use a combinational 32x32 signed/unsigned multiplier.
  - Accepted at E0 → HI/LO written at E1, busy=1 for exactly one cycle, done pulses the cycle after E1.
  - DIV path and the MUL state are omitted from the MUL flow.
- Undefined: the iterative 33-cycle MUL path described above.

Decomposition:
- Shared package holds:
  - op_code constants MD_MULT..MD_MTLO.
  - FSM state encoding.
  - DIV0_LO = 32'hFFFFFFFF.
  - MD_ITER = 32.
- One sub-module, muldiv_core: the iterative shift-add/restoring step engine (accumulator, counter, sign fix). muldiv_ctrl keeps the FSM, handshake, cancel and HI/LO.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF → busy 33 cycles, done once, HI=0xFFFFFFFE, LO=0x00000001.
- MULT -3 (0xFFFFFFFD) * 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Also DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/7 → LO=14, HI=2. Also DIVU 5/0 → LO=0xFFFFFFFF, HI=5. Also DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles → hi_o=0x1234, lo_o=0x5678, busy never high. Also a DIV issued with a MULT held valid during busy → MULT accepted only after op_ready rises.
- DIVU started, cancel at cycle 10 → busy low next cycle, HI/LO keep prior values, no done. Also cancel together with MTLO → LO unchanged.
- resetn low at cycle 15 of a MULT → HI=LO=HILO_RESET, busy=0. A new op is accepted the cycle after reset releases.
